// File: rtl/spike_classifier.sv
// Winner-take-all readout for an SNN output layer: counts spikes per neuron over a
// window of snn_clk ticks, then serially scans the counters for the maximum.
module spike_classifier #(
    parameter int NUM_OUT = 10,
    parameter int CNT_W   = 8,
    parameter int WINDOW  = 64
) (
    input  logic                       sys_clk,
    input  logic                       rst_n,
    input  logic                       snn_clk,
    input  logic                       start,
    input  logic [NUM_OUT-1:0]         spike_in,
    input  logic                       result_ack,
    output logic                       busy,
    output logic                       result_valid,
    output logic [$clog2(NUM_OUT)-1:0] class_idx,
    output logic [CNT_W-1:0]           max_count,
    output logic                       tie,
    output logic                       no_spike,
    output logic [2:0]                 dbg_state_o
);

    localparam int IDX_W = $clog2(NUM_OUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);
    localparam logic [15:0]      WIN      = 16'(WINDOW);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_FLUSH = 3'd2,
        S_SCAN  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      tick_q, tick_d;
    logic [CNT_W-1:0] cnt_q [NUM_OUT];
    logic [CNT_W-1:0] cnt_d [NUM_OUT];
    logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
    logic [IDX_W-1:0] best_q, best_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic             tie_q, tie_d;
    logic             no_spike_q, no_spike_d;
    logic [CNT_W-1:0] scan_val;

    assign scan_val = cnt_q[scan_idx_q];

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        cnt_d      = cnt_q;
        scan_idx_d = scan_idx_q;
        best_d     = best_q;
        max_d      = max_q;
        tie_d      = tie_q;
        no_spike_d = no_spike_q;

        // FLUSH keeps counting so a spike registered just after the last tick lands.
        if (state_q == S_COUNT || state_q == S_FLUSH) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (spike_in[i] && cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_COUNT;
                    tick_d     = '0;
                    scan_idx_d = '0;
                    best_d     = '0;
                    max_d      = '0;
                    tie_d      = 1'b0;
                    no_spike_d = 1'b0;
                    for (int i = 0; i < NUM_OUT; i++) cnt_d[i] = '0;
                end
            end
            S_COUNT: begin
                if (snn_clk) begin
                    tick_d = tick_q + 16'd1;
                    if (tick_q + 16'd1 == WIN) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_d    = S_SCAN;
                scan_idx_d = '0;
            end
            S_SCAN: begin
                // Strict '>' keeps the lowest index on equal counts.
                if (scan_val > max_q) begin
                    max_d  = scan_val;
                    best_d = scan_idx_q;
                    tie_d  = 1'b0;
                end else if (scan_val == max_q && max_q != '0) begin
                    tie_d = 1'b1;
                end
                if (scan_idx_q == LAST_IDX) begin
                    state_d    = S_DONE;
                    no_spike_d = (max_d == '0);
                end else begin
                    scan_idx_d = scan_idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (result_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            scan_idx_q <= '0;
            best_q     <= '0;
            max_q      <= '0;
            tie_q      <= 1'b0;
            no_spike_q <= 1'b0;
            for (int i = 0; i < NUM_OUT; i++) cnt_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            scan_idx_q <= scan_idx_d;
            best_q     <= best_d;
            max_q      <= max_d;
            tie_q      <= tie_d;
            no_spike_q <= no_spike_d;
            for (int i = 0; i < NUM_OUT; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign result_valid = (state_q == S_DONE);
    assign class_idx    = best_q;
    assign max_count    = max_q;
    assign tie          = tie_q;
    assign no_spike     = no_spike_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_spike_classifier.sv
// Directed bench for spike_classifier: WINDOW=4, NUM_OUT=10, plus a CNT_W=3 copy
// on the same inputs for the saturation case.
module tb_spike_classifier;

    localparam int NUM_OUT = 10;
    localparam int LAT     = NUM_OUT + 2;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FLUSH = 3'd2;

    logic             sys_clk;
    logic             rst_n;
    logic             snn_clk;
    logic             start;
    logic [9:0]       spike_in;
    logic             result_ack;
    logic             busy, result_valid, tie, no_spike;
    logic [3:0]       class_idx;
    logic [7:0]       max_count;
    logic [2:0]       dbg_state;
    logic             s_busy, s_valid, s_tie, s_no_spike;
    logic [3:0]       s_idx;
    logic [2:0]       s_max;
    logic [2:0]       s_state;

    // {class_idx, max_count, tie, no_spike}
    logic [13:0] exp_q[$];
    logic [13:0] last_exp;
    int          errors = 0;
    int          checks = 0;

    spike_classifier #(.NUM_OUT(NUM_OUT), .CNT_W(8), .WINDOW(4)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .snn_clk(snn_clk), .start(start),
        .spike_in(spike_in), .result_ack(result_ack), .busy(busy),
        .result_valid(result_valid), .class_idx(class_idx), .max_count(max_count),
        .tie(tie), .no_spike(no_spike), .dbg_state_o(dbg_state)
    );

    spike_classifier #(.NUM_OUT(NUM_OUT), .CNT_W(3), .WINDOW(4)) dut_sat (
        .sys_clk(sys_clk), .rst_n(rst_n), .snn_clk(snn_clk), .start(start),
        .spike_in(spike_in), .result_ack(result_ack), .busy(s_busy),
        .result_valid(s_valid), .class_idx(s_idx), .max_count(s_max),
        .tie(s_tie), .no_spike(s_no_spike), .dbg_state_o(s_state)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [13:0] pack(input logic [3:0] idx, input logic [7:0] mx,
                                         input logic t, input logic ns);
        return {idx, mx, t, ns};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents inputs for one rising edge; returns 1 time unit after that edge.
    task automatic cyc(input logic s, input logic [9:0] sp, input logic st, input logic ak);
        snn_clk    = s;
        spike_in   = sp;
        start      = st;
        result_ack = ak;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic spikes(input logic [9:0] v, input int n);
        repeat (n) cyc(1'b0, v, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1'b1, 10'h000, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, result_valid, 0);
        chk({tag, "_idx"}, class_idx, 0);
        chk({tag, "_max"}, max_count, 0);
        chk({tag, "_tie"}, tie, 0);
        chk({tag, "_nospk"}, no_spike, 0);
        chk({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        cyc(1'b0, 10'h000, 1'b0, 1'b0);
        cyc(1'b0, 10'h000, 1'b0, 1'b0);
        check_zero(tag);
        rst_n = 1'b1;
    endtask

    task automatic begin_window(input logic [13:0] e);
        cyc(1'b0, 10'h000, 1'b1, 1'b0);
        exp_q.push_back(e);
    endtask

    // Final tick, then the FLUSH cycle and first SCAN cycle with the given spikes,
    // then a bounded wait for result_valid and a scoreboard compare.
    task automatic final_tick(input string tag, input logic [9:0] fspk, input logic [9:0] sspk);
        int lat;
        logic [13:0] e;
        cyc(1'b1, 10'h000, 1'b0, 1'b0);
        chk({tag, "_flush"}, dbg_state, ST_FLUSH);
        cyc(1'b0, fspk, 1'b0, 1'b0);
        cyc(1'b1, sspk, 1'b0, 1'b0);
        lat = 3;
        while (!result_valid && lat < 100) begin
            cyc(1'b0, 10'h000, 1'b0, 1'b0);
            lat++;
        end
        chk({tag, "_latency"}, lat, LAT);
        chk({tag, "_sb_nonempty"}, (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            last_exp = e;
            chk({tag, "_idx"}, class_idx, e[13:10]);
            chk({tag, "_max"}, max_count, e[9:2]);
            chk({tag, "_tie"}, tie, e[1]);
            chk({tag, "_nospk"}, no_spike, e[0]);
            chk({tag, "_busy"}, busy, 1);
        end
    endtask

    task automatic ack_result(input string tag);
        cyc(1'b0, 10'h000, 1'b0, 1'b1);
        chk({tag, "_ack_valid"}, result_valid, 0);
        chk({tag, "_ack_busy"}, busy, 0);
        chk({tag, "_ack_idx_held"}, class_idx, last_exp[13:10]);
        chk({tag, "_ack_max_held"}, max_count, last_exp[9:2]);
    endtask

    initial begin
        rst_n      = 1'b0;
        snn_clk    = 1'b0;
        start      = 1'b0;
        spike_in   = '0;
        result_ack = 1'b0;
        last_exp   = '0;
        @(posedge sys_clk);
        #1;
        do_reset("reset");

        // Neuron 3 x3, neuron 7 x1; start/ack during COUNT must be ignored.
        begin_window(pack(4'd3, 8'd3, 1'b0, 1'b0));
        spikes(10'h008, 1);
        cyc(1'b0, 10'h008, 1'b1, 1'b1);
        spikes(10'h008, 1);
        spikes(10'h080, 1);
        ticks(3);
        final_tick("t1", 10'h000, 10'h000);
        ack_result("t1");

        // Neurons 2 and 5 tie at 4; lowest index wins.
        begin_window(pack(4'd2, 8'd4, 1'b1, 1'b0));
        spikes(10'h024, 4);
        ticks(3);
        final_tick("t2", 10'h000, 10'h000);
        ack_result("t2");

        // Tie at 2 between 1 and 4 is cleared by neuron 8 at 5.
        begin_window(pack(4'd8, 8'd5, 1'b0, 1'b0));
        spikes(10'h012, 2);
        ticks(1);
        spikes(10'h100, 5);
        ticks(2);
        final_tick("t2b", 10'h000, 10'h000);
        ack_result("t2b");

        // No spikes in the window; spikes in IDLE beforehand are not counted.
        spikes(10'h3ff, 2);
        begin_window(pack(4'd0, 8'd0, 1'b0, 1'b1));
        ticks(3);
        final_tick("t3", 10'h000, 10'h000);
        ack_result("t3");

        // Neuron 0 x10: 8-bit copy reads 10, 3-bit copy saturates at 7.
        begin_window(pack(4'd0, 8'd10, 1'b0, 1'b0));
        spikes(10'h001, 6);
        ticks(2);
        spikes(10'h001, 4);
        ticks(1);
        final_tick("t4", 10'h000, 10'h000);
        chk("t4_sat_max", s_max, 7);
        chk("t4_sat_idx", s_idx, 0);
        chk("t4_sat_valid", s_valid, 1);
        chk("t4_sat_nospk", s_no_spike, 0);
        ack_result("t4");

        // Neuron 1: one spike in COUNT, one in FLUSH (counted), one in first SCAN (not).
        begin_window(pack(4'd1, 8'd2, 1'b0, 1'b0));
        spikes(10'h002, 1);
        ticks(3);
        final_tick("t5", 10'h002, 10'h002);
        ack_result("t5");

        // Reset mid-SCAN.
        cyc(1'b0, 10'h000, 1'b1, 1'b0);
        spikes(10'h004, 2);
        ticks(4);
        cyc(1'b0, 10'h000, 1'b0, 1'b0);
        cyc(1'b0, 10'h000, 1'b0, 1'b0);
        do_reset("rst_scan");

        // Reset mid-COUNT, then a clean window with no spikes.
        cyc(1'b0, 10'h000, 1'b1, 1'b0);
        spikes(10'h010, 3);
        ticks(2);
        do_reset("rst_count");
        begin_window(pack(4'd0, 8'd0, 1'b0, 1'b1));
        ticks(3);
        final_tick("t6", 10'h000, 10'h000);

        // start alone in DONE is ignored; start with ack only returns to IDLE.
        cyc(1'b0, 10'h000, 1'b1, 1'b0);
        chk("t6_start_in_done_valid", result_valid, 1);
        chk("t6_start_in_done_nospk", no_spike, 1);
        cyc(1'b0, 10'h000, 1'b1, 1'b1);
        chk("t6_start_ack_busy", busy, 0);
        chk("t6_start_ack_valid", result_valid, 0);
        cyc(1'b0, 10'h000, 1'b0, 1'b0);
        chk("t6_not_queued", busy, 0);

        chk("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
